result_uart_tx: RTL
===================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives clock cycles per UART bit (50 MHz, 115200 baud).
REQ-002 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port valid  input  1  level from the matcher; high while a match result is held.
REQ-005 Port x_out  input  10  match X coordinate, unsigned 0..1023.
REQ-006 Port y_out  input  9  match Y coordinate, unsigned 0..511.
REQ-007 Port txd  output  1  UART serial line, idle high.
REQ-008 Port busy  output  1  high from the cycle after capture until the cycle sendComplete pulses.
REQ-009 Port sendComplete  output  1  single-cycle pulse after the stop bit of the last byte.

Function
REQ-010 The block SHALL capture x_out/y_out on the cycle valid is high and was low on the previous cycle, only while in IDLE.
REQ-011 A valid rising edge outside IDLE SHALL be ignored, with no queuing; valid held high SHALL NOT retrigger.
REQ-012 FSM states: IDLE -> CONVERT (on capture) -> SEND (after 10 convert cycles) -> DONE (after last byte's stop bit) -> IDLE (next cycle).
REQ-013 CONVERT SHALL run a shift-add-3 binary-to-BCD for exactly 10 cycles, X (4 digits) and Y (zero-extended to 10 bits, 3 digits) in parallel.
REQ-014 The transmitted frame SHALL be 10 ASCII bytes: X thousands, hundreds, tens, units, ',', Y hundreds, tens, units, 0x0D, 0x0A.
REQ-015 Digits SHALL be 0x30+BCD, leading zeros included (X=7 -> "0007").
REQ-016 Each byte SHALL be sent as a start bit (0), 8 data bits LSB first, and a stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-017 Consecutive bytes SHALL be back-to-back with no idle bit between them.
REQ-018 The first start bit SHALL begin on the first cycle of SEND.
REQ-019 sendComplete SHALL be high only in DONE, for exactly one cycle.
REQ-020 busy SHALL be low in IDLE and in DONE.
REQ-021 Captured values SHALL be immune to x_out/y_out changes after capture.

Reset
REQ-022 On reset the block SHALL go to IDLE, with txd=1, busy=0, sendComplete=0, and the bit counter, byte counter, and baud counter at 0.
REQ-023 Reset asserted mid-frame SHALL abort immediately, leaving txd high.
REQ-024 No partial frame SHALL resume after reset release.
REQ-025 A valid already high at reset release SHALL NOT trigger a send; valid is sampled as previously high out of reset.

Configuration
REQ-026 Macro RESULT_TX_PARITY_EN defined: each byte SHALL carry an even-parity bit between data bit 7 and the stop bit (11 bits per byte).
REQ-027 Macro RESULT_TX_PARITY_EN undefined: 10 bits per byte, no parity logic.

Structure
REQ-028 A shared package SHALL hold the FSM state encodings, the ASCII constants (0x30, 0x2C, 0x0D, 0x0A), and the frame length 10.
REQ-029 One sub-module, uart_tx_serializer, SHALL handle the bit-level byte transmission.
REQ-030 uart_tx_serializer SHALL use a start/byte input and a done handshake to the frame FSM.
REQ-031 BCD conversion and frame sequencing SHALL remain in result_uart_tx.

Verification (CLKS_PER_BIT=4 in bench)
REQ-032 x=123, y=45, valid rises: decoded bytes "0123,045\r\n", sendComplete once, 10 cycles + 10*10*4 cycles after capture.
REQ-033 x=1023, y=511: bytes "1023,511\r\n"; x=0, y=0: bytes "0000,000\r\n".
REQ-034 valid pulses again during SEND: exactly one frame is sent, and busy stays high continuously.
REQ-035 x_out changed to 999 on the cycle after capture: the frame still carries the originally captured value.
REQ-036 reset asserted during byte 5: txd=1, busy=0 the same cycle, no sendComplete; a new valid rising edge then yields a full frame.
REQ-037 RESULT_TX_PARITY_EN defined, x=1: byte '1' (0x31) carries parity bit 1, and each byte lasts 11*4 cycles.

Source files
------------

// File: rtl/result_uart_tx_pkg.sv
// Shared constants for the match-result UART reporter: FSM encoding, ASCII codes, frame geometry.
// Build option: define RESULT_TX_PARITY_EN to append an even-parity bit to every byte.
package result_uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] FRAME_LEN      = 4'd10;
  localparam logic [3:0] CONVERT_CYCLES = 4'd10;

`ifdef RESULT_TX_PARITY_EN
  localparam logic [3:0] BITS_PER_BYTE = 4'd11;
`else
  localparam logic [3:0] BITS_PER_BYTE = 4'd10;
`endif

  // One shift-add-3 correction step for a single BCD digit.
  function automatic logic [3:0] bcd_adj4(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/result_uart_tx_serializer.sv
// Bit-level UART byte transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Build option: RESULT_TX_PARITY_EN inserts the parity bit before the stop bit.
module uart_tx_serializer
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       txd_o,
  output logic       done_o,
  output logic       active_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_BAUD = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT  = BITS_PER_BYTE - 4'd1;

  logic          active_q, active_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [7:0]    data_q, data_d;

  // Handshake: start_i is taken only while idle; that same cycle already drives the
  // start bit, so the baud counter loads with 1 (CLKS_PER_BIT must be at least 2).
  // done_o pulses on the final cycle of the stop bit, and the line is idle again next cycle.
  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    data_d   = data_q;
    done_o   = 1'b0;
    if (!active_q) begin
      if (start_i) begin
        active_d = 1'b1;
        bit_d    = 4'd0;
        baud_d   = CW'(1);
        data_d   = data_i;
      end
    end else if (baud_q == LAST_BAUD) begin
      baud_d = '0;
      if (bit_q == LAST_BIT) begin
        done_o   = 1'b1;
        active_d = 1'b0;
        bit_d    = 4'd0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + CW'(1);
    end
  end

  always_comb begin
    txd_o = 1'b1;
    if (!active_q)
      txd_o = ~start_i;
    else if (bit_q == 4'd0)
      txd_o = 1'b0;
    else if (bit_q <= 4'd8)
      txd_o = data_q[3'(bit_q - 4'd1)];
`ifdef RESULT_TX_PARITY_EN
    else if (bit_q == 4'd9)
      txd_o = ^data_q;
`endif
  end

  assign active_o = active_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      baud_q   <= '0;
      data_q   <= 8'h00;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Reports a matcher result over UART as "XXXX,YYY\r\n": captures on valid rising edge,
// converts to BCD, then sequences the ten bytes. Build option: RESULT_TX_PARITY_EN.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid,
  input  logic [9:0] x_out,
  input  logic [8:0] y_out,
  output logic       txd,
  output logic       busy,
  output logic       sendComplete
);

  state_t      state_q, state_d;
  logic        valid_q;
  logic [9:0]  x_bin_q, x_bin_d, y_bin_q, y_bin_d;
  logic [15:0] x_bcd_q, x_bcd_d, x_adj;
  logic [11:0] y_bcd_q, y_bcd_d, y_adj;
  logic [3:0]  conv_cnt_q, conv_cnt_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic        ser_start, ser_done, ser_active;
  logic [7:0]  ser_data;

  assign x_adj = {bcd_adj4(x_bcd_q[15:12]), bcd_adj4(x_bcd_q[11:8]),
                  bcd_adj4(x_bcd_q[7:4]),   bcd_adj4(x_bcd_q[3:0])};
  assign y_adj = {bcd_adj4(y_bcd_q[11:8]), bcd_adj4(y_bcd_q[7:4]), bcd_adj4(y_bcd_q[3:0])};

  always_comb begin
    state_d      = state_q;
    x_bin_d      = x_bin_q;
    y_bin_d      = y_bin_q;
    x_bcd_d      = x_bcd_q;
    y_bcd_d      = y_bcd_q;
    conv_cnt_d   = conv_cnt_q;
    byte_idx_d   = byte_idx_q;
    ser_start    = 1'b0;
    busy         = 1'b0;
    sendComplete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid && !valid_q) begin
          x_bin_d    = x_out;
          y_bin_d    = {1'b0, y_out};
          x_bcd_d    = '0;
          y_bcd_d    = '0;
          conv_cnt_d = 4'd0;
          byte_idx_d = 4'd0;
          state_d    = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        busy       = 1'b1;
        x_bcd_d    = {x_adj[14:0], x_bin_q[9]};
        y_bcd_d    = {y_adj[10:0], y_bin_q[9]};
        x_bin_d    = {x_bin_q[8:0], 1'b0};
        y_bin_d    = {y_bin_q[8:0], 1'b0};
        conv_cnt_d = conv_cnt_q + 4'd1;
        if (conv_cnt_q == CONVERT_CYCLES - 4'd1)
          state_d = ST_SEND;
      end
      ST_SEND: begin
        busy = 1'b1;
        // The serializer drops active the cycle after done, so the next start bit follows directly.
        ser_start = !ser_active;
        if (ser_done) begin
          if (byte_idx_q == FRAME_LEN - 4'd1)
            state_d = ST_DONE;
          else
            byte_idx_d = byte_idx_q + 4'd1;
        end
      end
      ST_DONE: begin
        sendComplete = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (byte_idx_q)
      4'd0:    ser_data = ASCII_ZERO + {4'h0, x_bcd_q[15:12]};
      4'd1:    ser_data = ASCII_ZERO + {4'h0, x_bcd_q[11:8]};
      4'd2:    ser_data = ASCII_ZERO + {4'h0, x_bcd_q[7:4]};
      4'd3:    ser_data = ASCII_ZERO + {4'h0, x_bcd_q[3:0]};
      4'd4:    ser_data = ASCII_COMMA;
      4'd5:    ser_data = ASCII_ZERO + {4'h0, y_bcd_q[11:8]};
      4'd6:    ser_data = ASCII_ZERO + {4'h0, y_bcd_q[7:4]};
      4'd7:    ser_data = ASCII_ZERO + {4'h0, y_bcd_q[3:0]};
      4'd8:    ser_data = ASCII_CR;
      default: ser_data = ASCII_LF;
    endcase
  end

  // valid_q resets high so a level already present at reset release is not an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b1;
      x_bin_q    <= '0;
      y_bin_q    <= '0;
      x_bcd_q    <= '0;
      y_bcd_q    <= '0;
      conv_cnt_q <= 4'd0;
      byte_idx_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid;
      x_bin_q    <= x_bin_d;
      y_bin_q    <= y_bin_d;
      x_bcd_q    <= x_bcd_d;
      y_bcd_q    <= y_bcd_d;
      conv_cnt_q <= conv_cnt_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clock    (clock),
    .reset    (reset),
    .start_i  (ser_start),
    .data_i   (ser_data),
    .txd_o    (txd),
    .done_o   (ser_done),
    .active_o (ser_active)
  );

endmodule
